uart_tx_arbiter: RTL and testbench



---
 rtl/uart_arb_pkg.sv | 20 ++
 rtl/rr_pick.sv | 30 +++
 rtl/uart_tx_arbiter.sv | 179 +++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_arb_pkg.sv
// rtl/uart_arb_pkg.sv - shared types and defaults for the UART TX arbiter
package uart_arb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ARB,
    LOAD,
    WAIT_BUSY,
    WAIT_DONE
  } arb_state_e;

  localparam int DEFAULT_DATA_WIDTH     = 8;
  localparam int DEFAULT_TIMEOUT_CYCLES = 4800000;

  // Pointer width for an n-entry round-robin, never narrower than one bit.
  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin picker: first valid index at or after ptr
module rr_pick
  import uart_arb_pkg::*;
#(
  parameter int N  = 2,
  parameter int PW = ptr_width(N)
) (
  input  logic [N-1:0]  valid,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  pick,
  output logic          any
);

  logic [PW:0] idx;

  always_comb begin
    pick = '0;
    any  = 1'b0;
    idx  = '0;
    for (int k = 0; k < N; k++) begin
      idx = {1'b0, ptr} + (PW+1)'(k);
      if (idx >= (PW+1)'(N)) idx = idx - (PW+1)'(N);
      if (!any && valid[idx[PW-1:0]]) begin
        pick[idx[PW-1:0]] = 1'b1;
        any               = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin, packet-locked sharing of one UART transmitter
// Optional idle-owner forced release: UART_ARB_TIMEOUT_EN
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ        = 2,
  parameter int DATA_WIDTH     = DEFAULT_DATA_WIDTH,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic                          clk_48mhz,
  input  logic                          reset_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_last,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [NUM_REQ-1:0]            grant,
  output logic                          tx_start,
  output logic [DATA_WIDTH-1:0]         tx_data,
  input  logic                          tx_busy,
  output logic                          timeout_flag
);

  localparam int PW = ptr_width(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("uart_tx_arbiter: unsupported parameter values");
  end

  arb_state_e            state_q, state_d;
  logic [NUM_REQ-1:0]    grant_q, grant_d;
  logic [NUM_REQ-1:0]    req_ready_q, req_ready_d;
  logic [PW-1:0]         owner_q, owner_d;
  logic [PW-1:0]         rr_ptr_q, rr_ptr_d;
  logic                  lock_q, lock_d;
  logic                  tx_start_q, tx_start_d;
  logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;

  logic [NUM_REQ-1:0]    pick;
  logic                  pick_any;
  logic [PW-1:0]         pick_idx;
  logic [PW-1:0]         sel_idx;
  logic                  sel_valid;

`ifdef UART_ARB_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            timeout_flag_q, timeout_flag_d;
`endif

  function automatic logic [PW-1:0] ptr_after(input logic [PW-1:0] i);
    return (i == PW'(NUM_REQ - 1)) ? '0 : i + 1'b1;
  endfunction

  rr_pick #(.N(NUM_REQ), .PW(PW)) u_rr_pick (
    .valid (req_valid),
    .ptr   (rr_ptr_q),
    .pick  (pick),
    .any   (pick_any)
  );

  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick[i]) pick_idx = PW'(i);
    end
  end

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    owner_d     = owner_q;
    lock_d      = lock_q;
    rr_ptr_d    = rr_ptr_q;
    tx_start_d  = 1'b0;
    req_ready_d = '0;
    tx_data_d   = tx_data_q;
    // A locked owner is the only candidate; nobody else may cut in mid-packet.
    sel_idx     = lock_q ? owner_q : pick_idx;
    sel_valid   = lock_q ? req_valid[owner_q] : pick_any;

    unique case (state_q)
      IDLE: begin
        if (!tx_busy && (|req_valid)) state_d = ARB;
      end
      ARB: begin
        if (sel_valid) begin
          owner_d          = sel_idx;
          grant_d          = '0;
          grant_d[sel_idx] = 1'b1;
          // Byte is captured here so start, data and ready all appear together in LOAD.
          lock_d           = !req_last[sel_idx];
          if (req_last[sel_idx]) rr_ptr_d = ptr_after(sel_idx);
          tx_data_d              = req_data[sel_idx*DATA_WIDTH +: DATA_WIDTH];
          tx_start_d             = 1'b1;
          req_ready_d[sel_idx]   = 1'b1;
          state_d                = LOAD;
        end else begin
          state_d = IDLE;
        end
      end
      LOAD: begin
        state_d = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (tx_busy) state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (!tx_busy) begin
          if (!lock_q) grant_d = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

`ifdef UART_ARB_TIMEOUT_EN
    to_cnt_d       = to_cnt_q;
    timeout_flag_d = timeout_flag_q;
    if (state_q == LOAD) begin
      to_cnt_d = '0;
    end else if (lock_q && (state_q == IDLE || state_q == ARB) && !req_valid[owner_q]) begin
      if (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
        to_cnt_d       = '0;
        lock_d         = 1'b0;
        grant_d        = '0;
        rr_ptr_d       = ptr_after(owner_q);
        timeout_flag_d = 1'b1;
        state_d        = IDLE;
      end else begin
        to_cnt_d = to_cnt_q + 1'b1;
      end
    end
`endif
  end

  always_ff @(posedge clk_48mhz) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      owner_q     <= '0;
      lock_q      <= 1'b0;
      rr_ptr_q    <= '0;
      tx_start_q  <= 1'b0;
      req_ready_q <= '0;
      tx_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      owner_q     <= owner_d;
      lock_q      <= lock_d;
      rr_ptr_q    <= rr_ptr_d;
      tx_start_q  <= tx_start_d;
      req_ready_q <= req_ready_d;
      tx_data_q   <= tx_data_d;
    end
  end

`ifdef UART_ARB_TIMEOUT_EN
  always_ff @(posedge clk_48mhz) begin
    if (!reset_n) begin
      to_cnt_q       <= '0;
      timeout_flag_q <= 1'b0;
    end else begin
      to_cnt_q       <= to_cnt_d;
      timeout_flag_q <= timeout_flag_d;
    end
  end

  assign timeout_flag = timeout_flag_q;
`else
  assign timeout_flag = 1'b0;
`endif

  assign grant     = grant_q;
  assign req_ready = req_ready_q;
  assign tx_start  = tx_start_q;
  assign tx_data   = tx_data_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - directed and randomized checks of uart_tx_arbiter
module tb_uart_tx_arbiter;

  localparam int N  = 3;
  localparam int DW = 8;
`ifdef UART_ARB_TIMEOUT_EN
  localparam int STALL = 10;
`else
  localparam int STALL = 100;
`endif

  logic              clk_48mhz = 1'b0;
  logic              reset_n;
  logic [N-1:0]      req_valid;
  logic [N*DW-1:0]   req_data;
  logic [N-1:0]      req_last;
  logic [N-1:0]      req_ready;
  logic [N-1:0]      grant;
  logic              tx_start;
  logic [DW-1:0]     tx_data;
  logic              tx_busy;
  logic              timeout_flag;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [16:0] rq [N][$];
  int          stall [N];
  int          vrise [N];
  int          ready_cnt [N];
  logic [11:0] got [$];
  int          got_cyc [$];
  logic [11:0] exp_q [$];
  int          start_cyc = 0;
  int          rst_cyc   = -1;
  int          blen_min  = 3;
  int          blen_max  = 3;
  int          ucnt      = 0;
  logic [7:0]  cur_byte  = 8'h00;

  int          m_ptr = 0;
  int          plen [N][$];
  logic [7:0]  mb [N][$];

  uart_tx_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(16)) dut (
    .clk_48mhz    (clk_48mhz),
    .reset_n      (reset_n),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_last     (req_last),
    .req_ready    (req_ready),
    .grant        (grant),
    .tx_start     (tx_start),
    .tx_data      (tx_data),
    .tx_busy      (tx_busy),
    .timeout_flag (timeout_flag)
  );

  always #10 clk_48mhz = ~clk_48mhz;
  always @(posedge clk_48mhz) cyc <= cyc + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, errors=%0d", errors);
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [3:0] idx_of(input logic [N-1:0] v);
    idx_of = 4'hf;
    for (int i = 0; i < N; i++) if (v[i]) idx_of = 4'(i);
  endfunction

  function automatic bit rq_empty();
    rq_empty = 1'b1;
    for (int i = 0; i < N; i++) if (rq[i].size() != 0) rq_empty = 1'b0;
  endfunction

  task automatic push(input int r, input logic [7:0] d, input logic last, input int st);
    rq[r].push_back({8'(st), last, d});
  endtask

  task automatic want(input int r, input logic [7:0] d);
    exp_q.push_back({4'(r), d});
  endtask

  task automatic wait_got(input int n, input int budget);
    int k = 0;
    while (got.size() < n && k < budget) begin
      @(posedge clk_48mhz); #2;
      k++;
    end
    chk("bytes_within_budget", 32'(got.size() >= n), 32'd1);
  endtask

  task automatic wait_idle(input int budget);
    int quiet = 0;
    int n = 0;
    while (quiet < 4 && n < budget) begin
      @(posedge clk_48mhz); #2;
      n++;
      if (rq_empty() && !tx_busy && grant == '0 && !tx_start) quiet++;
      else quiet = 0;
    end
    chk("settled_within_budget", 32'(quiet >= 4), 32'd1);
  endtask

  task automatic cmp_stream(input string tag);
    chk({tag, "_count"}, 32'(got.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      chk(tag, 32'((i < got.size()) ? got[i] : 12'hfff), 32'(exp_q[i]));
    got.delete();
    got_cyc.delete();
    exp_q.delete();
  endtask

  task automatic do_reset();
    @(posedge clk_48mhz); #2;
    reset_n = 1'b0;
    rst_cyc = cyc;
    repeat (2) @(posedge clk_48mhz);
    #2;
    reset_n = 1'b1;
  endtask

  // Requesters: present queue head, retire it on req_ready, optional stall afterwards.
  initial begin
    logic [16:0] e;
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    for (int i = 0; i < N; i++) begin stall[i] = 0; vrise[i] = 0; end
    forever begin
      @(posedge clk_48mhz); #1;
      for (int i = 0; i < N; i++) begin
        if (req_ready[i] && req_valid[i] && rq[i].size() > 0) begin
          e = rq[i].pop_front();
          stall[i] = int'(e[16:9]);
        end else if (stall[i] > 0) begin
          stall[i]--;
        end
        if (rq[i].size() > 0 && stall[i] == 0) begin
          e = rq[i][0];
          if (!req_valid[i]) vrise[i] = cyc;
          req_valid[i]          = 1'b1;
          req_data[i*DW +: DW]  = e[7:0];
          req_last[i]           = e[8];
        end else begin
          req_valid[i] = 1'b0;
        end
      end
    end
  end

  // UART model: busy follows a start, byte log records owner and data.
  initial begin
    tx_busy = 1'b0;
    for (int i = 0; i < N; i++) ready_cnt[i] = 0;
    forever begin
      @(posedge clk_48mhz); #1;
      for (int i = 0; i < N; i++) if (req_ready[i]) ready_cnt[i]++;
      if (tx_start) begin
        got.push_back({idx_of(grant), tx_data});
        got_cyc.push_back(cyc);
        start_cyc = cyc;
        cur_byte  = tx_data;
        chk("ready_matches_grant", 32'(req_ready), 32'(grant));
        chk("grant_onehot", 32'($onehot(grant)), 32'd1);
        ucnt = $urandom_range(blen_max, blen_min);
      end else begin
        if (req_ready != '0) chk("ready_without_start", 32'(req_ready), 32'd0);
        if (ucnt > 0) begin
          ucnt--;
          if (ucnt == 0 && rst_cyc < start_cyc)
            chk("tx_data_stable", 32'(tx_data), 32'(cur_byte));
        end
      end
      tx_busy = (ucnt > 0);
    end
  end

  initial begin
    int total;
    int r;
    int len;
    int np;
    int st;
    bit found;
    logic [7:0] d;

    reset_n = 1'b0;
    repeat (3) @(posedge clk_48mhz);
    #2;
    chk("reset_req_ready", 32'(req_ready), 32'd0);
    chk("reset_grant", 32'(grant), 32'd0);
    chk("reset_tx_start", 32'(tx_start), 32'd0);
    chk("reset_tx_data", 32'(tx_data), 32'd0);
    chk("reset_timeout_flag", 32'(timeout_flag), 32'd0);
    reset_n = 1'b1;

    // Single requester, single-byte packet.
    @(posedge clk_48mhz); #2;
    push(0, 8'h41, 1'b1, 0);
    want(0, 8'h41);
    wait_got(1, 50);
    chk("single_latency", 32'(start_cyc - vrise[0]), 32'd2);
    chk("single_tx_data", 32'(tx_data), 32'h41);
    @(posedge clk_48mhz); #2;
    chk("single_grant_held", 32'(grant), 32'b001);
    for (int k = 0; k < 50 && tx_busy; k++) begin @(posedge clk_48mhz); #2; end
    @(posedge clk_48mhz); #2;
    chk("single_grant_released", 32'(grant), 32'd0);
    wait_idle(200);
    chk("single_ready_pulses", 32'(ready_cnt[0]), 32'd1);
    cmp_stream("single");

    // Two requesters with back-to-back single-byte packets alternate.
    do_reset();
    push(0, 8'hAA, 1'b1, 0); push(0, 8'hAA, 1'b1, 0);
    push(1, 8'h55, 1'b1, 0); push(1, 8'h55, 1'b1, 0);
    want(0, 8'hAA); want(1, 8'h55); want(0, 8'hAA); want(1, 8'h55);
    wait_idle(500);
    cmp_stream("alternate");

    // Packet lock: req1 waits for req0's whole packet.
    do_reset();
    push(0, 8'h48, 1'b0, 0); push(0, 8'h49, 1'b0, 0); push(0, 8'h0A, 1'b1, 0);
    push(1, 8'h5A, 1'b1, 0);
    want(0, 8'h48); want(0, 8'h49); want(0, 8'h0A); want(1, 8'h5A);
    wait_idle(500);
    cmp_stream("packet_lock");

    // Owner stall mid-packet keeps the lock.
    push(0, 8'h48, 1'b0, STALL); push(0, 8'h49, 1'b1, 0);
    push(1, 8'h5A, 1'b1, 0);
    want(0, 8'h48); want(0, 8'h49); want(1, 8'h5A);
    wait_got(1, 50);
    repeat (STALL / 2) @(posedge clk_48mhz);
    #2;
    chk("stall_grant_held", 32'(grant), 32'b001);
    wait_idle(1000);
    cmp_stream("owner_stall");

    // Reset while waiting for the UART to finish; pointer returns to 0.
    blen_min = 30; blen_max = 30;
    push(0, 8'h11, 1'b1, 0);
    want(0, 8'h11);
    wait_got(1, 50);
    repeat (4) @(posedge clk_48mhz);
    #2;
    reset_n = 1'b0;
    rst_cyc = cyc;
    @(posedge clk_48mhz); #2;
    reset_n = 1'b1;
    chk("midreset_grant", 32'(grant), 32'd0);
    chk("midreset_req_ready", 32'(req_ready), 32'd0);
    chk("midreset_tx_start", 32'(tx_start), 32'd0);
    push(1, 8'h22, 1'b1, 0);
    push(0, 8'h33, 1'b1, 0);
    want(0, 8'h33); want(1, 8'h22);
    wait_idle(1000);
    chk("no_arb_while_busy", 32'((got_cyc.size() > 1) && (got_cyc[1] - got_cyc[0] >= 30)), 32'd1);
    cmp_stream("mid_reset");

    // Randomized packets against a packet-level round-robin model.
    blen_min = 2; blen_max = 8;
    do_reset();
    m_ptr = 0;
    for (int round = 0; round < 8; round++) begin
      total = 0;
      for (int q = 0; q < N; q++) begin
        np = $urandom_range(0, 3);
        for (int p = 0; p < np; p++) begin
          len = $urandom_range(1, 4);
          plen[q].push_back(len);
          total++;
          for (int j = 0; j < len; j++) begin
            d  = 8'($urandom);
            st = (j != len - 1 && $urandom_range(0, 3) == 0) ? $urandom_range(1, 12) : 0;
            push(q, d, 1'(j == len - 1), st);
            mb[q].push_back(d);
          end
        end
      end
      while (total > 0) begin
        found = 1'b0;
        r = 0;
        for (int k = 0; k < N; k++) begin
          if (!found && plen[(m_ptr + k) % N].size() > 0) begin
            r = (m_ptr + k) % N;
            found = 1'b1;
          end
        end
        len = plen[r].pop_front();
        for (int j = 0; j < len; j++) want(r, mb[r].pop_front());
        m_ptr = (r + 1) % N;
        total--;
      end
      wait_idle(4000);
      cmp_stream("random");
    end

`ifdef UART_ARB_TIMEOUT_EN
    push(0, 8'h10, 1'b0, 0);
    want(0, 8'h10);
    wait_got(1, 50);
    chk("timeout_flag_before", 32'(timeout_flag), 32'd0);
    push(1, 8'h33, 1'b1, 0);
    want(1, 8'h33);
    wait_got(2, 300);
    chk("timeout_flag_set", 32'(timeout_flag), 32'd1);
    chk("timeout_waited", 32'((got_cyc.size() > 1) && (got_cyc[1] - got_cyc[0] >= 16)), 32'd1);
    wait_idle(500);
    cmp_stream("timeout");
    do_reset();
    chk("timeout_flag_cleared", 32'(timeout_flag), 32'd0);
`else
    chk("timeout_flag_tied_low", 32'(timeout_flag), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
